// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register-select aliases, MEM-stage FSM
// states and the MEM/WB control bundle.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {IDLE, REQ, HELD} mem_state_t;

   typedef struct packed {
      logic     wen;
      logic     memToReg;
      logic     luiFlag;
      logic     halt;
      regbits_t wsel;
   } wbCtrl_t;

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// MEM/WB pipeline register: loads on enable, loads a bubble when flushed,
// otherwise holds.
module mem_wb_reg
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              en,
   input  logic              flush,
   input  wbCtrl_t           ctrlIn,
   input  logic [WORD_W-1:0] outPortIn,
   input  logic [WORD_W-1:0] loadIn,
   input  logic [WORD_W-1:0] instrIn,
   output wbCtrl_t           ctrlQ,
   output logic [WORD_W-1:0] outPortQ,
   output logic [WORD_W-1:0] loadQ,
   output logic [WORD_W-1:0] instrQ
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ctrlQ    <= '0;
         outPortQ <= '0;
         loadQ    <= '0;
         instrQ   <= '0;
      end else if (en) begin
         if (flush) begin
            ctrlQ    <= '0;
            outPortQ <= '0;
            loadQ    <= '0;
            instrQ   <= '0;
         end else begin
            ctrlQ    <= ctrlIn;
            outPortQ <= outPortIn;
            loadQ    <= loadIn;
            instrQ   <= instrIn;
         end
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues dcache requests from EX/MEM, stalls until
// dhit, buffers load data while held, and feeds the MEM/WB register.
module mem_stage_ctrl
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              memcuDRE,
   input  logic              memcuDWE,
   input  logic              memcuHALT,
   input  logic              memMemToReg,
   input  logic              memWEN,
   input  logic              memLUIflag,
   input  logic [4:0]        memwsel,
   input  logic [WORD_W-1:0] memOutput_Port,
   input  logic [WORD_W-1:0] memrdat2,
   input  logic [WORD_W-1:0] meminstr,
   input  logic              extStall,
   input  logic              flush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              memStall,
   output logic              wbWEN,
   output logic              wbMemToReg,
   output logic              wbLUIflag,
   output logic              wbHALT,
   output logic [4:0]        wbwsel,
   output logic [WORD_W-1:0] wbOutput_Port,
   output logic [WORD_W-1:0] wbdmemload,
   output logic [WORD_W-1:0] wbinstr,
   output logic              halt,
   output logic [CNT_W-1:0]  dstallCnt
);

   mem_state_t        state, stateNxt;
   logic [WORD_W-1:0] ldbuf, loadSel;
   logic [CNT_W-1:0]  stallCnt;
   logic              haltR, memop, request, advance, capture;
   wbCtrl_t           ctrlIn, ctrlQ;

   // Request is gated by nRST so nothing reaches the cache during reset.
   assign memop     = memcuDRE | memcuDWE;
   assign request   = nRST & ~haltR & memop & (state != HELD);
   assign dmemWEN   = request & memcuDWE;
   assign dmemREN   = request & memcuDRE & ~memcuDWE;
   assign memStall  = request & ~dhit;
   assign advance   = ~memStall & ~extStall;
   assign dmemaddr  = memOutput_Port;
   assign dmemstore = memrdat2;
   assign loadSel   = (state == HELD && !dhit) ? ldbuf : dmemload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      capture  = 1'b0;
      case (state)
         IDLE, REQ: begin
            if (request && !dhit) stateNxt = REQ;
            else if (request && extStall) begin
               stateNxt = HELD;
               capture  = 1'b1;
            end else stateNxt = IDLE;
         end
         HELD:    if (!extStall) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ldbuf    <= '0;
         haltR    <= 1'b0;
         stallCnt <= '0;
      end else begin
         if (capture) ldbuf <= dmemload;
         haltR <= haltR | ctrlQ.halt;
         if (memStall && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
      end
   end

   assign ctrlIn = '{wen: memWEN, memToReg: memMemToReg, luiFlag: memLUIflag,
                     halt: memcuHALT, wsel: memwsel};

   mem_wb_reg #(.WORD_W(WORD_W)) uWbReg (
      .CLK       (CLK),
      .nRST      (nRST),
      .en        (advance),
      .flush     (flush),
      .ctrlIn    (ctrlIn),
      .outPortIn (memOutput_Port),
      .loadIn    (loadSel),
      .instrIn   (meminstr),
      .ctrlQ     (ctrlQ),
      .outPortQ  (wbOutput_Port),
      .loadQ     (wbdmemload),
      .instrQ    (wbinstr)
   );

   assign wbWEN      = ctrlQ.wen;
   assign wbMemToReg = ctrlQ.memToReg;
   assign wbLUIflag  = ctrlQ.luiFlag;
   assign wbHALT     = ctrlQ.halt;
   assign wbwsel     = ctrlQ.wsel;
   assign halt       = haltR;
   assign dstallCnt  = stallCnt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model.
module tb_mem_stage_ctrl;

   logic        CLK, nRST;
   logic        memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag;
   logic [4:0]  memwsel;
   logic [31:0] memOutput_Port, memrdat2, meminstr;
   logic        extStall, flush, dhit;
   logic [31:0] dmemload;
   logic        dmemREN, dmemWEN, memStall;
   logic [31:0] dmemaddr, dmemstore;
   logic        wbWEN, wbMemToReg, wbLUIflag, wbHALT, halt;
   logic [4:0]  wbwsel;
   logic [31:0] wbOutput_Port, wbdmemload, wbinstr;
   logic [15:0] dstallCnt;

   int tests = 0;
   int fails = 0;

   mem_stage_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
      .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag),
      .memwsel(memwsel), .memOutput_Port(memOutput_Port), .memrdat2(memrdat2),
      .meminstr(meminstr), .extStall(extStall), .flush(flush), .dhit(dhit),
      .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .memStall(memStall),
      .wbWEN(wbWEN), .wbMemToReg(wbMemToReg), .wbLUIflag(wbLUIflag),
      .wbHALT(wbHALT), .wbwsel(wbwsel), .wbOutput_Port(wbOutput_Port),
      .wbdmemload(wbdmemload), .wbinstr(wbinstr), .halt(halt),
      .dstallCnt(dstallCnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearIn();
      memcuDRE = 0; memcuDWE = 0; memcuHALT = 0; memMemToReg = 0; memWEN = 0;
      memLUIflag = 0; memwsel = 0; memOutput_Port = 0; memrdat2 = 0;
      meminstr = 0; extStall = 0; flush = 0; dhit = 0; dmemload = 0;
   endtask

   task automatic doReset();
      clearIn();
      nRST = 0;
      tick();
      tick();
      nRST = 1;
      #1;
   endtask

   task automatic test_reset();
      doReset();
      nRST = 0;
      memcuDRE = 1; memOutput_Port = 32'h40;
      #1;
      tests++; if (dmemREN !== 1'b0) begin fails++; $display("FAIL reset_ren got %b want 0", dmemREN); end
      tests++; if (memStall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", memStall); end
      tests++;
      if ({wbWEN, wbMemToReg, wbLUIflag, wbHALT, wbwsel, wbOutput_Port, wbdmemload, wbinstr, halt, dstallCnt} !== '0) begin
         fails++; $display("FAIL reset_regs got wbinstr=%h halt=%b cnt=%0d want all 0", wbinstr, halt, dstallCnt);
      end
      doReset();
   endtask

   task automatic test_load_hit();
      doReset();
      memcuDRE = 1; memOutput_Port = 32'h100; dhit = 1; dmemload = 32'hDEADBEEF;
      memwsel = 5; memMemToReg = 1; memWEN = 1;
      #1;
      tests++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0) begin fails++; $display("FAIL hit_req got ren=%b wen=%b want 1 0", dmemREN, dmemWEN); end
      tests++; if (memStall !== 1'b0) begin fails++; $display("FAIL hit_stall got %b want 0", memStall); end
      tests++; if (dmemaddr !== 32'h100) begin fails++; $display("FAIL hit_addr got %h want 100", dmemaddr); end
      tick();
      tests++; if (wbdmemload !== 32'hDEADBEEF) begin fails++; $display("FAIL hit_wbload got %h want deadbeef", wbdmemload); end
      tests++; if (wbwsel !== 5'd5 || wbMemToReg !== 1'b1) begin fails++; $display("FAIL hit_wbctl got wsel=%0d m2r=%b want 5 1", wbwsel, wbMemToReg); end
      clearIn();
   endtask

   task automatic test_load_miss();
      doReset();
      memcuDRE = 1; memOutput_Port = 32'h100; memwsel = 7; memWEN = 1; memMemToReg = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h100 || memStall !== 1'b1) begin
            fails++; $display("FAIL miss_cyc%0d got ren=%b addr=%h stall=%b want 1 100 1", i, dmemREN, dmemaddr, memStall);
         end
         tick();
         tests++; if (wbwsel !== 5'd0) begin fails++; $display("FAIL miss_noload%0d got wsel=%0d want 0", i, wbwsel); end
      end
      dhit = 1; dmemload = 32'h0BADF00D;
      #1;
      tests++; if (memStall !== 1'b0) begin fails++; $display("FAIL miss_hitstall got %b want 0", memStall); end
      tick();
      tests++; if (dstallCnt !== 16'd3) begin fails++; $display("FAIL miss_cnt got %0d want 3", dstallCnt); end
      tests++; if (wbdmemload !== 32'h0BADF00D || wbwsel !== 5'd7) begin fails++; $display("FAIL miss_wb got %h/%0d want 0badf00d/7", wbdmemload, wbwsel); end
      clearIn();
   endtask

   task automatic test_store_held();
      doReset();
      memcuDWE = 1; memOutput_Port = 32'h200; memrdat2 = 32'h12345678;
      meminstr = 32'hABCD0001; dhit = 1; extStall = 1;
      #1;
      tests++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'h12345678) begin
         fails++; $display("FAIL st_issue got wen=%b ren=%b data=%h want 1 0 12345678", dmemWEN, dmemREN, dmemstore);
      end
      tick();
      dhit = 0;
      #1;
      tests++; if (dmemWEN !== 1'b0 || memStall !== 1'b0) begin fails++; $display("FAIL st_noreissue got wen=%b stall=%b want 0 0", dmemWEN, memStall); end
      tick();
      tests++; if (wbinstr !== 32'h0) begin fails++; $display("FAIL st_hold got %h want 0", wbinstr); end
      extStall = 0;
      #1;
      tests++; if (dmemWEN !== 1'b0) begin fails++; $display("FAIL st_release_wen got %b want 0", dmemWEN); end
      tick();
      tests++; if (wbinstr !== 32'hABCD0001) begin fails++; $display("FAIL st_wb got %h want abcd0001", wbinstr); end
      clearIn();
   endtask

   task automatic test_ldbuf();
      doReset();
      memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 9;
      dhit = 1; extStall = 1; dmemload = 32'hCAFEF00D;
      tick();
      dhit = 0; dmemload = 32'h0; extStall = 0;
      tick();
      tests++; if (wbdmemload !== 32'hCAFEF00D) begin fails++; $display("FAIL ldbuf got %h want cafef00d", wbdmemload); end
      clearIn();
   endtask

   task automatic test_flush();
      doReset();
      memWEN = 1; meminstr = 32'h77; memwsel = 3;
      tick();
      memcuDRE = 1; meminstr = 32'h1234; flush = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         tests++; if (memStall !== 1'b1 || dmemREN !== 1'b1) begin fails++; $display("FAIL fl_stall%0d got stall=%b ren=%b want 1 1", i, memStall, dmemREN); end
         tick();
         tests++; if (wbinstr !== 32'h77) begin fails++; $display("FAIL fl_hold%0d got %h want 77", i, wbinstr); end
      end
      dhit = 1;
      tick();
      tests++; if (wbWEN !== 1'b0 || wbinstr !== 32'h0 || wbwsel !== 5'd0) begin
         fails++; $display("FAIL fl_bubble got wen=%b instr=%h wsel=%0d want 0 0 0", wbWEN, wbinstr, wbwsel);
      end
      clearIn();
   endtask

   task automatic test_halt();
      doReset();
      memcuHALT = 1;
      tick();
      memcuHALT = 0;
      tests++; if (wbHALT !== 1'b1 || halt !== 1'b0) begin fails++; $display("FAIL halt_wb got wbHALT=%b halt=%b want 1 0", wbHALT, halt); end
      tick();
      tests++; if (halt !== 1'b1) begin fails++; $display("FAIL halt_sticky got %b want 1", halt); end
      memcuDRE = 1;
      #1;
      tests++; if (dmemREN !== 1'b0 || memStall !== 1'b0) begin fails++; $display("FAIL halt_noreq got ren=%b stall=%b want 0 0", dmemREN, memStall); end
      clearIn();
      doReset();
      memcuDRE = 1; memwsel = 4; memOutput_Port = 32'h300;
      tick();
      nRST = 0;
      #1;
      tests++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || memStall !== 1'b0 || dstallCnt !== 16'd0 || wbwsel !== 5'd0) begin
         fails++; $display("FAIL rst_in_req got ren=%b wen=%b stall=%b cnt=%0d want all 0", dmemREN, dmemWEN, memStall, dstallCnt);
      end
      clearIn();
      nRST = 1;
      #1;
   endtask

   task automatic test_random();
      bit          mHeld, mHalt, req, eRen, eWen, eStall, adv, nHalt;
      logic [31:0] mBuf;
      logic [15:0] mCnt;
      logic [4:0]  eWsel;
      logic        eWen2, eM2r, eLui, eHlt;
      logic [31:0] eOut, eLoad, eInstr;
      int          bad;
      doReset();
      mHeld = 0; mHalt = 0; mBuf = 0; mCnt = 0;
      eWsel = 0; eWen2 = 0; eM2r = 0; eLui = 0; eHlt = 0; eOut = 0; eLoad = 0; eInstr = 0;
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         memcuDRE = ($urandom_range(0, 9) < 4); memcuDWE = ($urandom_range(0, 9) < 3);
         memMemToReg = 1'($urandom); memWEN = 1'($urandom); memLUIflag = 1'($urandom);
         memwsel = 5'($urandom); memOutput_Port = $urandom; memrdat2 = $urandom;
         meminstr = $urandom; dmemload = $urandom;
         dhit = 1'($urandom); extStall = ($urandom_range(0, 9) < 3); flush = ($urandom_range(0, 9) < 2);
         req    = !mHeld && (memcuDRE || memcuDWE) && !mHalt;
         eRen   = req && memcuDRE && !memcuDWE;
         eWen   = req && memcuDWE;
         eStall = req && !dhit;
         adv    = !eStall && !extStall;
         #1;
         tests++;
         if (dmemREN !== eRen || dmemWEN !== eWen || memStall !== eStall || dmemaddr !== memOutput_Port || dmemstore !== memrdat2) begin
            fails++; bad++;
            if (bad < 5) $display("FAIL rnd_comb c=%0d got ren=%b wen=%b stall=%b want %b %b %b", c, dmemREN, dmemWEN, memStall, eRen, eWen, eStall);
         end
         nHalt = mHalt || eHlt;
         if (adv) begin
            if (flush) begin
               {eWen2, eM2r, eLui, eHlt, eWsel, eOut, eLoad, eInstr} = '0;
            end else begin
               eWen2 = memWEN; eM2r = memMemToReg; eLui = memLUIflag; eHlt = memcuHALT;
               eWsel = memwsel; eOut = memOutput_Port; eInstr = meminstr;
               eLoad = (mHeld && !dhit) ? mBuf : dmemload;
            end
         end
         if (eStall && mCnt != 16'hFFFF) mCnt = mCnt + 1;
         if (mHeld) mHeld = extStall;
         else if (req && dhit && extStall) begin mHeld = 1; mBuf = dmemload; end
         mHalt = nHalt;
         tick();
         tests++;
         if (wbWEN !== eWen2 || wbMemToReg !== eM2r || wbLUIflag !== eLui || wbHALT !== eHlt || wbwsel !== eWsel ||
             wbOutput_Port !== eOut || wbdmemload !== eLoad || wbinstr !== eInstr || halt !== mHalt || dstallCnt !== mCnt) begin
            fails++; bad++;
            if (bad < 5) $display("FAIL rnd_reg c=%0d got load=%h instr=%h cnt=%0d want %h %h %0d", c, wbdmemload, wbinstr, dstallCnt, eLoad, eInstr, mCnt);
         end
      end
      clearIn();
   endtask

   initial begin
      clearIn();
      nRST = 0;
      test_reset();
      test_load_hit();
      test_load_miss();
      test_store_held();
      test_ldbuf();
      test_flush();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
